// File: rtl/day1_ascii_parser_if.sv
// Byte-stream handshake feeding the day-1 ASCII parser.
// The source drives data/valid/last; the parser answers with ready.
interface day1_ascii_parser_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/day1_ascii_parser.sv
// Day-1 ASCII parser: turns a newline-separated decimal byte stream into
// DATA_W values, one next_val strobe per value, blank line -> value 0.
module day1_ascii_parser #(
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  day1_ascii_parser_if.slave    s_in,
  output logic [DATA_W-1:0]     par_input,
  output logic                  next_val,
  output logic                  done,
  output logic                  err_overflow,
  output logic                  err_bad_char,
  output logic [CNT_W-1:0]      value_count,
  output logic [CNT_W-1:0]      group_count
);

  localparam int                GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]     GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [DATA_W+3:0] TEN      = (DATA_W + 4)'(10);
  localparam logic [7:0]        CH_LF    = 8'h0A;
  localparam logic [7:0]        CH_CR    = 8'h0D;

  typedef enum logic [2:0] {
    S_LINE, S_NUM, S_SETUP, S_PULSE, S_GAP, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_acc, w_acc_nxt;
  logic                r_blank, w_blank_nxt;
  logic                r_last, w_last_nxt;
  logic [GW-1:0]       r_gap, w_gap_nxt;
  logic [DATA_W-1:0]   r_par;
  logic                r_next_val;
  logic                r_err_ovf, r_err_bad;
  logic [CNT_W-1:0]    r_vcnt, r_gcnt;

  logic                w_ready, w_accept;
  logic                w_is_digit;
  logic [DATA_W+3:0]   w_prod;
  logic                w_ovf;
  logic [DATA_W-1:0]   w_dig_val;

  logic                w_emit, w_flush_ok;
  logic [DATA_W-1:0]   w_emit_val, w_flush_val;
  logic                w_load, w_inc_v, w_inc_g, w_set_ovf, w_set_bad;

  assign w_ready         = (r_state == S_LINE) || (r_state == S_NUM);
  assign s_in.in_ready   = w_ready;
  assign w_accept        = s_in.in_valid && w_ready;

  // Digit path: widen by 4 bits so acc*10+9 can never wrap before the overflow test.
  assign w_is_digit = (s_in.in_data >= 8'h30) && (s_in.in_data <= 8'h39);
  assign w_prod     = ({4'd0, r_acc} * TEN) + {{DATA_W{1'b0}}, s_in.in_data[3:0]};
  assign w_ovf      = |w_prod[DATA_W+3:DATA_W];
  assign w_dig_val  = w_ovf ? {DATA_W{1'b1}} : w_prod[DATA_W-1:0];

  // Next-state and per-byte decisions: classify the accepted byte, decide whether
  // it triggers an emit (newline or end-of-file flush), and sequence the strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_blank_nxt = r_blank;
    w_last_nxt  = r_last;
    w_gap_nxt   = r_gap;
    w_emit      = 1'b0;
    w_emit_val  = '0;
    w_flush_ok  = 1'b0;
    w_flush_val = '0;
    w_load      = 1'b0;
    w_inc_v     = 1'b0;
    w_inc_g     = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_bad   = 1'b0;

    case (r_state)
      S_LINE, S_NUM: begin
        if (w_accept) begin
          if (w_is_digit) begin
            w_acc_nxt   = w_dig_val;
            w_set_ovf   = w_ovf;
            w_state_nxt = S_NUM;
            w_flush_ok  = 1'b1;
            w_flush_val = w_dig_val;
          end else if (s_in.in_data == CH_LF) begin
            w_acc_nxt   = '0;
            w_state_nxt = S_LINE;
            if (r_state == S_NUM) begin
              // a line of only zeros carries no calories and is dropped
              if (r_acc != '0) begin
                w_emit     = 1'b1;
                w_emit_val = r_acc;
              end
            end else if (!r_blank && !s_in.in_last) begin
              // first blank after a value closes the group; the file's end never does
              w_emit     = 1'b1;
              w_emit_val = '0;
            end
          end else begin
            // CR is silently skipped; anything else is flagged and skipped
            w_set_bad   = (s_in.in_data != CH_CR);
            w_flush_ok  = (r_state == S_NUM);
            w_flush_val = r_acc;
          end

          if (s_in.in_last) begin
            w_last_nxt = 1'b1;
            // a number not terminated by newline is still delivered
            if (!w_emit && w_flush_ok && (w_flush_val != '0)) begin
              w_emit     = 1'b1;
              w_emit_val = w_flush_val;
              w_acc_nxt  = '0;
            end
            if (!w_emit) w_state_nxt = S_DONE;
          end

          if (w_emit) begin
            w_load      = 1'b1;
            w_state_nxt = S_SETUP;
            if (w_emit_val != '0) begin
              w_inc_v     = 1'b1;
              w_blank_nxt = 1'b0;
            end else begin
              w_inc_g     = 1'b1;
              w_blank_nxt = 1'b1;
            end
          end
        end
      end
      S_SETUP: w_state_nxt = S_PULSE;
      S_PULSE: begin
        w_state_nxt = S_GAP;
        w_gap_nxt   = GAP_LOAD;
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = r_last ? S_DONE : S_LINE;
        else             w_gap_nxt   = r_gap - 1'b1;
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_LINE;
    endcase
  end

  // Control state: FSM, accumulator, blank-line tracking, end-of-file and gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LINE;
      r_acc   <= '0;
      r_blank <= 1'b1;
      r_last  <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_blank <= w_blank_nxt;
      r_last  <= w_last_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // Output value is loaded on the accepting edge and held until the next emit,
  // which gives one full cycle of setup before the strobe and hold after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_par <= '0;
    else if (w_load) r_par <= w_emit_val;
  end

  // Strobe is high for exactly the cycle following S_SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_next_val <= 1'b0;
    else        r_next_val <= (r_state == S_SETUP);
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_bad <= 1'b0;
    end else begin
      if (w_set_ovf) r_err_ovf <= 1'b1;
      if (w_set_bad) r_err_bad <= 1'b1;
    end
  end

  // Saturating emit counters: nonzero values and group separators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vcnt <= '0;
      r_gcnt <= '0;
    end else begin
      if (w_inc_v && (r_vcnt != {CNT_W{1'b1}})) r_vcnt <= r_vcnt + 1'b1;
      if (w_inc_g && (r_gcnt != {CNT_W{1'b1}})) r_gcnt <= r_gcnt + 1'b1;
    end
  end

  assign par_input    = r_par;
  assign next_val     = r_next_val;
  assign done         = (r_state == S_DONE);
  assign err_overflow = r_err_ovf;
  assign err_bad_char = r_err_bad;
  assign value_count  = r_vcnt;
  assign group_count  = r_gcnt;

endmodule

// File: tb/tb_day1_ascii_parser.sv
// Directed bench for day1_ascii_parser: table of whole-file vectors plus
// hand-timed sequences for handshake timing, overflow progression and reset.
module tb_day1_ascii_parser;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  day1_ascii_parser_if ifc();

  logic [DW-1:0] par_input;
  logic          next_val, done, err_overflow, err_bad_char;
  logic [CW-1:0] value_count, group_count;

  day1_ascii_parser #(.DATA_W(DW), .GAP_CYCLES(1), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_in         (ifc.slave),
    .par_input    (par_input),
    .next_val     (next_val),
    .done         (done),
    .err_overflow (err_overflow),
    .err_bad_char (err_bad_char),
    .value_count  (value_count),
    .group_count  (group_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: logs each strobe's value, width, setup/hold stability and the
  // number of low cycles since the previous strobe.
  logic [DW-1:0] q_val[$];
  int            q_width[$];
  bit            q_pre[$];
  bit            q_post[$];
  int            q_gap[$];
  logic          nv_d;
  logic [DW-1:0] par_d, par_at_rise;
  int            hi_run, lo_run;
  bit            in_pulse, seen;

  always @(negedge clk) begin
    if (!rst_n) begin
      nv_d     <= 1'b0;
      hi_run   <= 0;
      lo_run   <= 0;
      in_pulse <= 1'b0;
      seen     <= 1'b0;
      par_d    <= par_input;
    end else begin
      if (next_val && !nv_d) begin
        q_val.push_back(par_input);
        q_pre.push_back(par_input == par_d);
        q_gap.push_back(seen ? lo_run : 999);
        par_at_rise <= par_input;
        hi_run      <= 1;
        in_pulse    <= 1'b1;
      end else if (next_val) begin
        hi_run <= hi_run + 1;
      end else if (in_pulse) begin
        q_width.push_back(hi_run);
        q_post.push_back(par_input == par_at_rise);
        in_pulse <= 1'b0;
        seen     <= 1'b1;
        lo_run   <= 1;
      end else begin
        lo_run <= lo_run + 1;
      end
      nv_d  <= next_val;
      par_d <= par_input;
    end
  end

  typedef struct packed {
    logic [3:0][31:0] ev;
    logic [7:0]       n;
    logic [15:0]      vc;
    logic [15:0]      gc;
    logic             ovf;
    logic             bad;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] e0, e1, e2, e3, input int n, vc, gc,
                              input logic ovf, bad);
    vec_t v;
    v.ev[0] = e0; v.ev[1] = e1; v.ev[2] = e2; v.ev[3] = e3;
    v.n = 8'(n); v.vc = 16'(vc); v.gc = 16'(gc); v.ovf = ovf; v.bad = bad;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit last);
    int t = 0;
    ifc.in_data  = b;
    ifc.in_last  = last;
    ifc.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (ifc.in_ready) break;
      t++;
      if (t > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=0 for 50 cycles, required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input bit last_at_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_at_end && (i == s.len() - 1));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done", 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.in_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  vec_t  vecs[4];
  string stim[4];
  int    bv, bw;

  initial begin
    vecs[0] = mk(32'd1000, 32'd2000, 32'd0, 32'd3000, 4, 3, 1, 1'b0, 1'b0);
    stim[0] = "1000\n2000\n\n3000\n";
    vecs[1] = mk(32'd5, 32'd0, 32'd7, 32'd0, 3, 2, 1, 1'b0, 1'b0);
    stim[1] = "\n\n5\n\n\n\n7";
    vecs[2] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 2, 2, 0, 1'b1, 1'b0);
    stim[2] = "4294967295\n4294967296\n";
    vecs[3] = mk(32'd12, 32'd34, 32'd0, 32'd0, 2, 2, 0, 1'b0, 1'b1);
    stim[3] = "12\015\n3a4\n0\n";

    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.in_data  = 8'h00;

    // reset state
    #3;
    chk("rst_par",   64'(par_input),    64'd0);
    chk("rst_nv",    64'(next_val),     64'd0);
    chk("rst_done",  64'(done),         64'd0);
    chk("rst_ovf",   64'(err_overflow), 64'd0);
    chk("rst_bad",   64'(err_bad_char), 64'd0);
    chk("rst_vcnt",  64'(value_count),  64'd0);
    chk("rst_gcnt",  64'(group_count),  64'd0);

    // whole-file vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      bv = q_val.size();
      bw = q_width.size();
      send_str(stim[v], 1'b1);
      wait_done();
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_npulse", v), 64'(q_val.size() - bv), 64'(vecs[v].n));
      for (int i = 0; i < int'(vecs[v].n) && (bv + i) < q_val.size(); i++) begin
        chk($sformatf("v%0d_val%0d", v, i), 64'(q_val[bv+i]), 64'(vecs[v].ev[i]));
        chk($sformatf("v%0d_setup%0d", v, i), 64'(q_pre[bv+i]), 64'd1);
        if (i > 0) chk($sformatf("v%0d_gap%0d", v, i), 64'(q_gap[bv+i] >= 2), 64'd1);
      end
      for (int i = 0; i < int'(vecs[v].n) && (bw + i) < q_width.size(); i++) begin
        chk($sformatf("v%0d_width%0d", v, i), 64'(q_width[bw+i]), 64'd1);
        chk($sformatf("v%0d_hold%0d", v, i), 64'(q_post[bw+i]), 64'd1);
      end
      chk($sformatf("v%0d_vcnt", v), 64'(value_count),  64'(vecs[v].vc));
      chk($sformatf("v%0d_gcnt", v), 64'(group_count),  64'(vecs[v].gc));
      chk($sformatf("v%0d_ovf", v),  64'(err_overflow), 64'(vecs[v].ovf));
      chk($sformatf("v%0d_bad", v),  64'(err_bad_char), 64'(vecs[v].bad));
      chk($sformatf("v%0d_ready", v), 64'(ifc.in_ready), 64'd0);
    end

    // overflow flag progression: clear after max value, set after max+1
    do_reset();
    send_str("4294967295\n", 1'b0);
    repeat (4) @(negedge clk);
    chk("ovf_after_max", 64'(err_overflow), 64'd0);
    chk("par_max",       64'(par_input),    64'hFFFF_FFFF);
    send_str("4294967296\n", 1'b1);
    wait_done();
    chk("ovf_after_max1", 64'(err_overflow), 64'd1);
    chk("par_sat",        64'(par_input),    64'hFFFF_FFFF);

    // valid held high: ready timing around one emit
    do_reset();
    bv = q_val.size();
    ifc.in_valid = 1'b1;
    ifc.in_data  = "1";
    @(posedge clk); #1;
    ifc.in_data  = "\n";
    @(posedge clk); #1;                 // '\n' accepted -> S_SETUP
    ifc.in_data  = "2";
    chk("hs_setup_ready", 64'(ifc.in_ready), 64'd0);
    chk("hs_setup_nv",    64'(next_val),     64'd0);
    chk("hs_setup_par",   64'(par_input),    64'd1);
    @(posedge clk); #1;                 // S_PULSE
    chk("hs_pulse_ready", 64'(ifc.in_ready), 64'd0);
    chk("hs_pulse_nv",    64'(next_val),     64'd1);
    chk("hs_pulse_par",   64'(par_input),    64'd1);
    @(posedge clk); #1;                 // S_GAP
    chk("hs_gap_ready",   64'(ifc.in_ready), 64'd0);
    chk("hs_gap_nv",      64'(next_val),     64'd0);
    chk("hs_gap_par",     64'(par_input),    64'd1);
    @(posedge clk); #1;                 // back in S_LINE
    chk("hs_line_ready",  64'(ifc.in_ready), 64'd1);
    @(posedge clk); #1;                 // '2' accepted
    ifc.in_data  = "\n";
    ifc.in_last  = 1'b1;
    @(posedge clk); #1;                 // final '\n' accepted
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    chk("hs_npulse", 64'(q_val.size() - bv), 64'd2);
    if (q_val.size() >= bv + 2) begin
      chk("hs_val0", 64'(q_val[bv]),   64'd1);
      chk("hs_val1", 64'(q_val[bv+1]), 64'd2);
    end
    chk("hs_vcnt", 64'(value_count), 64'd2);

    // reset in the middle of a strobe
    do_reset();
    send_str("8\n", 1'b0);              // returns 1ns after the accepting edge
    @(posedge clk); #1;                 // S_PULSE
    chk("mid_nv_before", 64'(next_val), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_nv_rst",   64'(next_val),    64'd0);
    chk("mid_par_rst",  64'(par_input),   64'd0);
    chk("mid_vcnt_rst", 64'(value_count), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    bv = q_val.size();
    send_str("9\n", 1'b1);
    wait_done();
    repeat (2) @(negedge clk);
    chk("mid_npulse", 64'(q_val.size() - bv), 64'd1);
    if (q_val.size() > bv) chk("mid_val", 64'(q_val[bv]), 64'd9);
    chk("mid_vcnt", 64'(value_count), 64'd1);
    chk("mid_gcnt", 64'(group_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
